// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - memory and decode-side signal bundle for fetch_sequencer
//
// Purpose: groups the memory pins, the redirect input and the decode handshake.
// Signals:
//   mem_data_i       memory read data (Memory.data_o)
//   mem_address_o    memory address (Memory.address_i), registered
//   mem_write_en_no  memory write enable, active-low, always 1
//   redirect_i       one-cycle pulse that loads the PC from redirect_addr_i
//   redirect_addr_i  redirect target
//   instr_o          fetched instruction word
//   instr_pc_o       address instr_o was read from
//   instr_valid_o    instr_o / instr_pc_o hold a valid word
//   instr_ready_i    decode accepts the word on this edge
//   vector_busy_o    high while the reset vector is being read
// Modports: master = fetch_sequencer side, slave = memory/decode side.
interface fetch_sequencer_if #(
  parameter int DataWidth    = 16,
  parameter int AddressWidth = 8
);
  logic [DataWidth-1:0]    mem_data_i;
  logic [AddressWidth-1:0] mem_address_o;
  logic                    mem_write_en_no;
  logic                    redirect_i;
  logic [AddressWidth-1:0] redirect_addr_i;
  logic [DataWidth-1:0]    instr_o;
  logic [AddressWidth-1:0] instr_pc_o;
  logic                    instr_valid_o;
  logic                    instr_ready_i;
  logic                    vector_busy_o;

  modport master (
    input  mem_data_i,
    input  redirect_i,
    input  redirect_addr_i,
    input  instr_ready_i,
    output mem_address_o,
    output mem_write_en_no,
    output instr_o,
    output instr_pc_o,
    output instr_valid_o,
    output vector_busy_o
  );

  modport slave (
    output mem_data_i,
    output redirect_i,
    output redirect_addr_i,
    output instr_ready_i,
    input  mem_address_o,
    input  mem_write_en_no,
    input  instr_o,
    input  instr_pc_o,
    input  instr_valid_o,
    input  vector_busy_o
  );
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch front end with reset vector and redirect
//
// Purpose: reads the reset vector word at VectorAddress, loads the PC from it,
// then streams sequential instruction words to decode over valid/ready.
// A redirect pulse reloads the PC and flushes the output slot.
// Ports:
//   clk_i    clock, rising edge
//   reset_i  synchronous active-high reset
//   bus      fetch_sequencer_if.master (memory pins, redirect, decode handshake)
module fetch_sequencer #(
  parameter int                    DataWidth     = 16,
  parameter int                    AddressWidth  = 8,
  parameter logic [AddressWidth-1:0] VectorAddress = {AddressWidth{1'b1}}
) (
  input  logic             clk_i,
  input  logic             reset_i,
  fetch_sequencer_if.master bus
);

  typedef enum logic {
    VECTOR = 1'b0,
    FETCH  = 1'b1
  } state_t;

  state_t                  r_state;
  logic [AddressWidth-1:0] r_addr;
  logic [DataWidth-1:0]    r_instr;
  logic [AddressWidth-1:0] r_pc;
  logic                    r_valid;

  state_t                  w_state_nxt;
  logic [AddressWidth-1:0] w_addr_nxt;
  logic [DataWidth-1:0]    w_instr_nxt;
  logic [AddressWidth-1:0] w_pc_nxt;
  logic                    w_valid_nxt;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= VECTOR;
      r_addr  <= VectorAddress;
      r_instr <= '0;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_instr <= w_instr_nxt;
      r_pc    <= w_pc_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_instr_nxt = r_instr;
    w_pc_nxt    = r_pc;
    w_valid_nxt = r_valid;
    case (r_state)
      VECTOR: begin
        // Vector word is at mem_data_i now; only its low bits form the PC.
        w_addr_nxt  = bus.mem_data_i[AddressWidth-1:0];
        w_state_nxt = FETCH;
      end
      FETCH: begin
        if (bus.redirect_i) begin
          // Flush: whatever sits in the slot is dropped, no capture this edge.
          w_addr_nxt  = bus.redirect_addr_i;
          w_valid_nxt = 1'b0;
        end else if (!r_valid || bus.instr_ready_i) begin
          w_instr_nxt = bus.mem_data_i;
          w_pc_nxt    = r_addr;
          w_valid_nxt = 1'b1;
          w_addr_nxt  = r_addr + 1'b1;
        end
      end
      default: begin
        w_state_nxt = VECTOR;
      end
    endcase
  end

  assign bus.mem_address_o   = r_addr;
  assign bus.mem_write_en_no = 1'b1;
  assign bus.instr_o         = r_instr;
  assign bus.instr_pc_o      = r_pc;
  assign bus.instr_valid_o   = r_valid;
  assign bus.vector_busy_o   = (r_state == VECTOR);

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch front end that sits directly upstream of `Memory` and drives its address and write-enable pins. Out of reset it reads the reset vector word at `VectorAddress`, loads the program counter from it, then streams sequential instruction words to the decode stage over a valid/ready handshake. It also accepts a single-cycle redirect (branch or jump) that flushes the output slot.

## Interface
- `DataWidth`, 16: memory and instruction word width.
- `AddressWidth`, 8: memory address width; the PC is this wide.
- `VectorAddress`, `{AddressWidth{1'b1}}` (0xFF): location of the reset vector word.

- `clk_i`  in  1: single clock; all state updates on the rising edge.
- `reset_i`  in  1: synchronous, active-high reset.
- `mem_data_i`  in  DataWidth: `Memory.data_o`.
- `mem_address_o`  out  AddressWidth: `Memory.address_i`, registered.
- `mem_write_en_no`  out  1: `Memory.write_en_ni`; tied to 1 (the block never writes).
- `redirect_i`  in  1: a one-cycle pulse that loads the PC from `redirect_addr_i`.
- `redirect_addr_i`  in  AddressWidth: redirect target.
- `instr_o`  out  DataWidth: fetched instruction word, registered.
- `instr_pc_o`  out  AddressWidth: address `instr_o` was read from.
- `instr_valid_o`  out  1: `instr_o` / `instr_pc_o` hold a valid word.
- `instr_ready_i`  in  1: decode accepts the word on this edge when `instr_valid_o` is high.
- `vector_busy_o`  out  1: high while in state VECTOR.

## Operation
- Memory read model: an address registered on edge N gives valid `mem_data_i` for capture on edge N+1. Read latency is one cycle, and data stays stable while the address is held.
- States: VECTOR, FETCH.
- Reset (`reset_i`=1 on an edge):
  - state ← VECTOR
  - `mem_address_o` ← `VectorAddress`
  - `instr_valid_o` ← 0
  - `instr_o` ← 0, `instr_pc_o` ← 0
  - `mem_write_en_no` = 1 at all times.
- VECTOR, on the first edge with `reset_i`=0:
  - `mem_address_o` ← `mem_data_i[AddressWidth-1:0]`
  - state ← FETCH
  - `redirect_i` is ignored in this state.
  - Upper data bits are discarded.
- FETCH, per edge, in priority order:
  1. `redirect_i`=1:
     - `mem_address_o` ← `redirect_addr_i`
     - `instr_valid_o` ← 0 (flush; any unaccepted word is dropped)
     - no capture this edge.
  2. Else, slot free (`instr_valid_o`=0, or `instr_ready_i`=1):
     - `instr_o` ← `mem_data_i`
     - `instr_pc_o` ← `mem_address_o`
     - `instr_valid_o` ← 1
     - `mem_address_o` ← `mem_address_o`+1
  3. Else (stall): all registers hold.
- PC arithmetic: modulo 2^AddressWidth. 0xFF+1 = 0x00.
- Fetching `VectorAddress` in FETCH is legal; the word is treated as an ordinary instruction.
- A word is consumed only on an edge where `instr_valid_o`=1 and `instr_ready_i`=1.

## Timing
- Reset release to vector capture: 1 edge.
- Reset release to first `instr_valid_o`: 2 edges.
- Steady state with `instr_ready_i`=1: one word per cycle, no bubbles.
- Redirect on edge N: `instr_valid_o`=0 after N; first target word valid after N+1 (one bubble).
- Stall: `instr_o`, `instr_pc_o`, `instr_valid_o` and `mem_address_o` remain unchanged until the edge where ready is seen.
- Reset mid-stream: next edge forces `instr_valid_o`=0 and `mem_address_o`=`VectorAddress`; the full vector sequence reruns.
- Simultaneous `redirect_i` and `instr_ready_i`: redirect wins. The current word counts as accepted and the slot empties.

## Test plan
Memory preload for all scenarios: 0x00=0x00FF, 0x01=0xF0F0, 0x02=0x1234, 0xFE=0xBEEF, 0xFF=0x0001.

- **Reset release:**
  - Stimulus: reset 2 cycles, then release, ready=1.
  - Required response: `mem_address_o`=0xFF during VECTOR, then 0x01. Edge 2 gives `instr_o`=0xF0F0, `instr_pc_o`=0x01, valid=1.
- **Streaming:**
  - Stimulus: ready=1 continuously.
  - Required response: consecutive words 0xF0F0/0x01, then 0x1234/0x02, one per cycle.
- **Backpressure:**
  - Stimulus: ready=0 for 3 cycles while valid.
  - Required response: `instr_o`=0x1234, `instr_pc_o`=0x02, `mem_address_o`=0x03 all held. After ready returns to 1, the next word is from 0x03.
- **Redirect:**
  - Stimulus: redirect to 0x00 while valid, ready=0.
  - Required response: valid=0 on the next cycle, then 0x00FF / pc 0x00. The stalled word is never re-presented.
- **Wrap:**
  - Stimulus: redirect to 0xFE, ready=1.
  - Required response: words 0xBEEF/0xFE, 0x0001/0xFF, 0x00FF/0x00 in consecutive cycles.
- **Reset mid-stream:**
  - Stimulus: assert reset for 1 cycle while valid=1.
  - Required response: valid=0 and address=0xFF after the edge; the reset-release sequence then repeats exactly. `mem_write_en_no`=1 throughout.
